// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sequential 8x8 multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mult_state_t;

  localparam int MULT_ITER = 8;
  localparam int PROD_W    = 16;

endpackage

// File: rtl/sixteen_bit_FA.sv
// rtl/sixteen_bit_FA.sv - 16-bit combinational ripple-carry adder
// Ports: A, B (16-bit addends), Cin (carry in), S (16-bit sum), Cout (carry out)
module sixteen_bit_FA (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  logic [16:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[16];

endmodule

// File: rtl/seq_shift_add_mult8.sv
// rtl/seq_shift_add_mult8.sv - sequential 8x8 unsigned shift-and-add multiplier
// Ports: clk, rst_n (async, active low); in_valid/in_ready with a, b (operands);
//        out_valid/out_ready with product (16-bit a*b)
module seq_shift_add_mult8
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);

  // The accumulator is the fixed 16-bit adder, so only 8-bit operands fit.
  if (WIDTH != 8) begin : g_width_check
    $error("seq_shift_add_mult8: WIDTH must be 8");
  end

  mult_state_t       state_q;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] mcand;
  logic [WIDTH-1:0]  mplr;
  logic [2:0]        cnt;
  logic [PROD_W-1:0] sum;
  // Product never exceeds 65025, so this carry is always zero; kept visible for checking.
  logic              cout_unused;

  sixteen_bit_FA u_acc_add (
    .A    (acc),
    .B    (mcand),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (cout_unused)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand   <= {{(PROD_W-WIDTH){1'b0}}, a};
            mplr    <= b;
            acc     <= '0;
            cnt     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (mplr[0]) begin
            acc <= sum;
          end
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 3'd1;
          // Fixed iteration count keeps latency independent of the operands.
          if (cnt == 3'(MULT_ITER - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult8.sv
// tb/tb_seq_shift_add_mult8.sv - directed and table-driven bench for seq_shift_add_mult8
module tb_seq_shift_add_mult8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  int vec_count = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t tbl[6];

  seq_shift_add_mult8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Adder carry-out must stay zero on every RUN cycle (in_ready and out_valid both low).
  always @(negedge clk) begin
    if (rst_n && !in_ready && !out_valid) begin
      chk("adder_cout_run", {31'd0, dut.cout_unused}, 32'd0);
    end
  end

  task automatic wait_result(input logic [15:0] exp, input string nm);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, 8);
    chk({nm, "_product"}, {16'd0, product}, {16'd0, exp});
  endtask

  longint last_accept = 0;

  // Expects out_ready already high and the block in IDLE; returns one step after the output handshake.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] exp,
                        input string nm, input bit check_ii);
    longint t;
    in_valid = 1'b1;
    a = va;
    b = vb;
    @(posedge clk);
    t = $time;
    if (check_ii) chk({nm, "_ii"}, 32'((t - last_accept) / 10), 10);
    last_accept = t;
    #1;
    in_valid = 1'b0;
    chk({nm, "_in_ready_run"}, {31'd0, in_ready}, 0);
    wait_result(exp, nm);
    @(posedge clk);
    #1;
    chk({nm, "_out_valid_drop"}, {31'd0, out_valid}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    logic [7:0] ra, rb;

    tbl[0] = '{8'd13,  8'd11,  16'd143};
    tbl[1] = '{8'd255, 8'd255, 16'hFE01};
    tbl[2] = '{8'd0,   8'd200, 16'd0};
    tbl[3] = '{8'd200, 8'd0,   16'd0};
    tbl[4] = '{8'd1,   8'd1,   16'd1};
    tbl[5] = '{8'd128, 8'd2,   16'd256};

    // Reset held 3 cycles with operands offered: nothing is captured.
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 8'd5;
    b = 8'd5;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_product", {16'd0, product}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) saw = 1'b1;
    end
    chk("reset_no_capture", {31'd0, saw}, 0);

    // Table vectors, back to back.
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("tbl%0d", i), i > 0);
    end

    // Backpressure: hold DONE 5 cycles, ignore an in_valid pulse there.
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 8'd7;
    b = 8'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(16'd63, "bp");
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2);
      a = 8'd3;
      b = 8'd3;
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {31'd0, out_valid}, 1);
      chk("bp_hold_product", {16'd0, product}, 63);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 0);
    end
    // Output handshake and in_valid together: only the output completes.
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 8'd9;
    b = 8'd9;
    @(posedge clk);
    #1;
    chk("simul_out_valid", {31'd0, out_valid}, 0);
    chk("simul_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("simul_accept_in_ready", {31'd0, in_ready}, 0);
    wait_result(16'd81, "simul");
    @(posedge clk);
    #1;
    chk("simul_out_valid_drop", {31'd0, out_valid}, 0);

    // Reset during RUN cycle 4: the operation is abandoned.
    in_valid = 1'b1;
    a = 8'd100;
    b = 8'd100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_product", {16'd0, product}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) saw = 1'b1;
    end
    chk("midrst_no_output", {31'd0, saw}, 0);
    run_op(8'd12, 8'd12, 16'd144, "after_rst", 1'b0);

    // Random stream at the minimum initiation interval.
    for (int i = 0; i < 50; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, 16'(ra) * 16'(rb), $sformatf("rnd%0d", i), i > 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
